kanagawa_hal_multi_channel_fifo: RTL and testbench
==================================================

Name: kanagawa_hal_multi_channel_fifo

Overview:
- Single-clock, show-ahead FIFO holding CHANNELS independent logical queues in one shared, statically partitioned storage array.
- One write port and one read port, each steered by a channel index.
- Per-channel full, almost_full, empty and usedw status, plus sticky overflow/underflow error flags.
- Sits in the HAL layer as the same-clock companion to the dual-clock FIFO, for multiplexed streams such as per-context or per-thread queues.

Parameters:
- CHANNELS, 4, number of logical queues; must be ≥1.
- CH_WIDTH, max(1,$clog2(CHANNELS)), channel-index width; checked at elaboration.
- DEPTH, 32, entries per channel; must be a power of 2, ≥2.
- LOG_DEPTH, $clog2(DEPTH), checked at elaboration.
- WIDTH, 64, data width in bits.
- USEDW_WIDTH, LOG_DEPTH+1, per-channel occupancy width.
- ALMOSTFULL_ENTRIES, 2, almost_full asserts when usedw ≥ DEPTH-ALMOSTFULL_ENTRIES; must be < DEPTH.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- wrreq  in  1  write strobe.
- wr_channel  in  CH_WIDTH  target queue for the write.
- data  in  WIDTH  write data.
- full  out  CHANNELS  per-channel full.
- almost_full  out  CHANNELS  per-channel almost full.
- usedw  out  CHANNELS*USEDW_WIDTH  per-channel occupancy; channel c occupies bits [c*USEDW_WIDTH +: USEDW_WIDTH].
- rdreq  in  1  read/pop strobe.
- rd_channel  in  CH_WIDTH  queue to view and pop.
- empty  out  CHANNELS  per-channel empty.
- q  out  WIDTH  head entry of rd_channel (show-ahead).
- overflow  out  1  sticky: a write hit a full channel.
- underflow  out  1  sticky: a read hit an empty channel.

Behaviour:
- Storage: CHANNELS*DEPTH entries, addressed {channel, ptr}.
  - Synchronous write.
  - Asynchronous (LUTRAM-style) read, so q is combinational from rd_channel and that channel's rd_ptr.
- Per channel: wr_ptr, rd_ptr (LOG_DEPTH bits, natural wrap DEPTH-1 → 0) and count (USEDW_WIDTH bits, range 0..DEPTH).
- Reset:
  - While rst=1, full and empty are forced to all-ones combinationally.
  - At the first edge with rst=1: all pointers and counts go to 0; overflow and underflow go to 0.
  - After rst falls: full=0, empty=all-ones, almost_full=0, usedw=0.
  - q is don't-care while empty.
  - Reset mid-operation discards all contents in one cycle.
- Status decode:
  - full[c] = rst | count==DEPTH.
  - empty[c] = rst | count==0.
  - almost_full[c] = count ≥ DEPTH-ALMOSTFULL_ENTRIES.
  - All decode from registered counts; no combinational path from wrreq/rdreq to status.
- Write accept: wrreq & ~full[wr_channel] & ~rst.
  - Accepted write stores data at wr_ptr and increments wr_ptr.
  - Latency: written at edge t; empty clears and usedw updates after edge t; q reflects it at t+1.
- Write to a full channel: dropped, pointers unchanged, overflow←1. This holds even when the same-cycle read frees a slot on that channel, because full is evaluated on the pre-edge count.
- Read accept: rdreq & ~empty[rd_channel] & ~rst.
  - Accepted read increments rd_ptr; q advances to the next entry after the edge.
- Read from an empty channel: ignored, underflow←1. A same-cycle write to that channel is still accepted (count 0→1). No bypass: q shows the new data from the next cycle.
- Simultaneous accepted read and write on the same channel: count unchanged, both pointers advance.
- Different channels: the two operations are fully independent.
- overflow/underflow: cleared only by rst.
- Elaboration errors: non-power-of-2 DEPTH, inconsistent LOG_DEPTH or CH_WIDTH, ALMOSTFULL_ENTRIES ≥ DEPTH, CHANNELS < 1.
- If CHANNELS is not a power of 2: an out-of-range channel index is treated as an access to a full/empty channel. The op is dropped and the corresponding error flag is set.

Decomposition:
- Shared package kanagawa_hal_fifo_pkg holds:
  - the clog2-based width helper functions;
  - a typedef for the per-channel state struct {wr_ptr, rd_ptr, count};
  - the parameter-legality check function, also usable by the dual-clock FIFO.
- Sub-module kanagawa_hal_fifo_channel_ctrl holds one channel's pointers, counter and status decode. It is instantiated CHANNELS times in a generate loop, with per-channel accept strobes driven by the top.

Test Plan:
- Reset, then idle → empty=4'b1111, full=0, almost_full=0, usedw all 0. With rst held high, full=4'b1111.
- Write 0xA0..0xBF (32 words) to ch2, then read 32 times → q matches in order; ch2 empty after the last read; other channels unaffected.
- Fill ch1 to 30 → almost_full[1]=1 at usedw=30, 0 at 29.
  - Fill to 32, then one more write → full[1]=1, overflow=1, usedw stays 32.
  - That write is dropped even with a same-cycle read on ch1.
- Read ch0 while empty, with a same-cycle write of 0x55 to ch0 → underflow=1, usedw[0]=1, q=0x55 next cycle.
- Interleave: write ch3 and read ch0 every cycle for 100 cycles, each starting at usedw=16 → ch3 ordering preserved, ch0 drains to 0, counts exact, pointers wrap correctly.
- Assert rst with ch1 half full → next cycle all empty, usedw=0, sticky flags cleared; the old data never reappears.

Source files
------------

// File: rtl/kanagawa_hal_fifo_pkg.sv
// Shared helpers and types for the HAL FIFO family (single- and dual-clock).
package kanagawa_hal_fifo_pkg;

  // Upper bound on LOG_DEPTH; sets the field widths of the shared channel-state struct.
  localparam int unsigned FIFO_MAX_LOG_DEPTH = 16;

  typedef logic [FIFO_MAX_LOG_DEPTH-1:0] fifo_ptr_t;
  typedef logic [FIFO_MAX_LOG_DEPTH:0]   fifo_cnt_t;

  // Per-channel bookkeeping; only the low LOG_DEPTH / LOG_DEPTH+1 bits are live.
  typedef struct packed {
    fifo_ptr_t wr_ptr;
    fifo_ptr_t rd_ptr;
    fifo_cnt_t count;
  } fifo_chan_state_t;

  function automatic int unsigned fifo_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Channel-index width; a single channel still gets a one-bit index.
  function automatic int unsigned fifo_ch_width(input int unsigned channels);
    return (channels <= 1) ? 1 : fifo_clog2(channels);
  endfunction

  function automatic bit fifo_params_ok(input int unsigned channels,
                                        input int unsigned ch_width,
                                        input int unsigned depth,
                                        input int unsigned log_depth,
                                        input int unsigned af_entries);
    bit ok;
    ok = 1'b1;
    if (channels < 1) ok = 1'b0;
    if (ch_width != fifo_ch_width(channels)) ok = 1'b0;
    if (depth < 2 || (depth & (depth - 1)) != 0) ok = 1'b0;
    if (log_depth != fifo_clog2(depth) || log_depth > FIFO_MAX_LOG_DEPTH) ok = 1'b0;
    if (af_entries >= depth) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/kanagawa_hal_fifo_channel_ctrl.sv
// One logical queue's pointers, occupancy counter and status decode.
module kanagawa_hal_fifo_channel_ctrl
  import kanagawa_hal_fifo_pkg::*;
#(
  parameter int unsigned DEPTH              = 32,
  parameter int unsigned LOG_DEPTH          = 5,
  parameter int unsigned USEDW_WIDTH        = 6,
  parameter int unsigned ALMOSTFULL_ENTRIES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_accept_i,
  input  logic                   rd_accept_i,
  output logic [LOG_DEPTH-1:0]   wr_ptr_o,
  output logic [LOG_DEPTH-1:0]   rd_ptr_o,
  output logic [USEDW_WIDTH-1:0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o
);

  localparam fifo_ptr_t PTR_MASK = fifo_ptr_t'(DEPTH - 1);
  localparam fifo_cnt_t CNT_FULL = fifo_cnt_t'(DEPTH);
  localparam fifo_cnt_t CNT_AF   = fifo_cnt_t'(DEPTH - ALMOSTFULL_ENTRIES);

  fifo_chan_state_t state_q, state_d;

  // Next state: pointers wrap naturally at DEPTH, count tracks net push/pop.
  always_comb begin
    state_d = state_q;
    if (wr_accept_i) state_d.wr_ptr = (state_q.wr_ptr + fifo_ptr_t'(1)) & PTR_MASK;
    if (rd_accept_i) state_d.rd_ptr = (state_q.rd_ptr + fifo_ptr_t'(1)) & PTR_MASK;
    case ({wr_accept_i, rd_accept_i})
      2'b10:   state_d.count = state_q.count + fifo_cnt_t'(1);
      2'b01:   state_d.count = state_q.count - fifo_cnt_t'(1);
      default: state_d.count = state_q.count;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  assign wr_ptr_o      = state_q.wr_ptr[LOG_DEPTH-1:0];
  assign rd_ptr_o      = state_q.rd_ptr[LOG_DEPTH-1:0];
  assign count_o       = state_q.count[USEDW_WIDTH-1:0];
  assign full_o        = rst | (state_q.count == CNT_FULL);
  assign empty_o       = rst | (state_q.count == '0);
  assign almost_full_o = (state_q.count >= CNT_AF);

endmodule

// File: rtl/kanagawa_hal_multi_channel_fifo.sv
// Single-clock show-ahead FIFO: CHANNELS queues statically partitioned in one array.
module kanagawa_hal_multi_channel_fifo
  import kanagawa_hal_fifo_pkg::*;
#(
  parameter int unsigned CHANNELS           = 4,
  parameter int unsigned CH_WIDTH           = fifo_ch_width(CHANNELS),
  parameter int unsigned DEPTH              = 32,
  parameter int unsigned LOG_DEPTH          = fifo_clog2(DEPTH),
  parameter int unsigned WIDTH              = 64,
  parameter int unsigned USEDW_WIDTH        = LOG_DEPTH + 1,
  parameter int unsigned ALMOSTFULL_ENTRIES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wrreq,
  input  logic [CH_WIDTH-1:0]             wr_channel,
  input  logic [WIDTH-1:0]                data,
  output logic [CHANNELS-1:0]             full,
  output logic [CHANNELS-1:0]             almost_full,
  output logic [CHANNELS*USEDW_WIDTH-1:0] usedw,
  input  logic                            rdreq,
  input  logic [CH_WIDTH-1:0]             rd_channel,
  output logic [CHANNELS-1:0]             empty,
  output logic [WIDTH-1:0]                q,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int unsigned AW      = CH_WIDTH + LOG_DEPTH;
  localparam int unsigned ENTRIES = CHANNELS * DEPTH;

  if (!fifo_params_ok(CHANNELS, CH_WIDTH, DEPTH, LOG_DEPTH, ALMOSTFULL_ENTRIES) ||
      USEDW_WIDTH != LOG_DEPTH + 1) begin : g_param_err
    $error("kanagawa_hal_multi_channel_fifo: illegal parameter combination");
  end

  logic [WIDTH-1:0]     mem [ENTRIES];
  logic [LOG_DEPTH-1:0] wr_ptr [CHANNELS];
  logic [LOG_DEPTH-1:0] rd_ptr [CHANNELS];
  logic [CHANNELS-1:0]  wr_en, rd_en;
  logic                 wr_in_range, rd_in_range;
  logic                 wr_blocked, rd_blocked;
  logic                 wr_accept, rd_accept;
  logic [AW-1:0]        wr_addr, rd_addr;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  // Unused codes of a non-power-of-2 channel index behave as a full/empty channel.
  assign wr_in_range = 32'(wr_channel) < CHANNELS;
  assign rd_in_range = 32'(rd_channel) < CHANNELS;
  assign wr_blocked  = ~wr_in_range | full[wr_channel];
  assign rd_blocked  = ~rd_in_range | empty[rd_channel];
  assign wr_accept   = wrreq & ~rst & ~wr_blocked;
  assign rd_accept   = rdreq & ~rst & ~rd_blocked;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign wr_en[c] = wr_accept & (wr_channel == CH_WIDTH'(c));
    assign rd_en[c] = rd_accept & (rd_channel == CH_WIDTH'(c));

    kanagawa_hal_fifo_channel_ctrl #(
      .DEPTH              (DEPTH),
      .LOG_DEPTH          (LOG_DEPTH),
      .USEDW_WIDTH        (USEDW_WIDTH),
      .ALMOSTFULL_ENTRIES (ALMOSTFULL_ENTRIES)
    ) u_ctrl (
      .clk           (clk),
      .rst           (rst),
      .wr_accept_i   (wr_en[c]),
      .rd_accept_i   (rd_en[c]),
      .wr_ptr_o      (wr_ptr[c]),
      .rd_ptr_o      (rd_ptr[c]),
      .count_o       (usedw[c*USEDW_WIDTH +: USEDW_WIDTH]),
      .full_o        (full[c]),
      .empty_o       (empty[c]),
      .almost_full_o (almost_full[c])
    );
  end

  assign wr_addr = {wr_channel, wr_ptr[wr_channel]};
  assign rd_addr = {rd_channel, rd_ptr[rd_channel]};

  // Synchronous write into the channel's partition.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_addr] <= data;
  end

  // Show-ahead: asynchronous read of the selected channel's head.
  assign q = mem[rd_addr];

  // Sticky error flags accumulate rejected requests until reset.
  always_comb begin
    overflow_d  = overflow_q  | (wrreq & wr_blocked);
    underflow_d = underflow_q | (rdreq & rd_blocked);
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_kanagawa_hal_multi_channel_fifo.sv
// Directed self-checking bench for the multi-channel FIFO (default parameters).
module tb_kanagawa_hal_multi_channel_fifo;

  logic        clk = 1'b0;
  logic        rst, wrreq, rdreq;
  logic [1:0]  wr_channel, rd_channel;
  logic [63:0] data, q;
  logic [3:0]  full, almost_full, empty;
  logic [23:0] usedw;
  logic        overflow, underflow;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  kanagawa_hal_multi_channel_fifo #(
    .CHANNELS (4),
    .DEPTH    (32),
    .WIDTH    (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wrreq       (wrreq),
    .wr_channel  (wr_channel),
    .data        (data),
    .full        (full),
    .almost_full (almost_full),
    .usedw       (usedw),
    .rdreq       (rdreq),
    .rd_channel  (rd_channel),
    .empty       (empty),
    .q           (q),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] uw(input int c);
    return usedw[c*6 +: 6];
  endfunction

  logic [63:0] m3[$];
  int unsigned c0, c3;

  initial begin
    rst = 1'b1; wrreq = 1'b0; rdreq = 1'b0;
    wr_channel = '0; rd_channel = '0; data = '0;

    // Reset behaviour
    step();
    chk("rst_full", full, 4'hF);
    chk("rst_empty", empty, 4'hF);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_unf", underflow, 1'b0);
    chk("rst_usedw", usedw, '0);
    rst = 1'b0;
    #1;
    chk("idle_full", full, 4'h0);
    chk("idle_empty", empty, 4'hF);
    chk("idle_af", almost_full, 4'h0);
    step();
    chk("idle_usedw", usedw, '0);

    // ch2: 32 writes then 32 ordered reads
    for (int i = 0; i < 32; i++) begin
      wrreq = 1'b1; wr_channel = 2'd2; data = 64'hA0 + 64'(i);
      step();
    end
    wrreq = 1'b0;
    chk("ch2_usedw32", uw(2), 6'd32);
    chk("ch2_full", full, 4'b0100);
    chk("ch2_empty", empty, 4'b1011);
    for (int i = 0; i < 32; i++) begin
      rd_channel = 2'd2; rdreq = 1'b1;
      #1;
      chk("ch2_q", q, 64'hA0 + 64'(i));
      step();
    end
    rdreq = 1'b0;
    chk("ch2_drained_empty", empty, 4'hF);
    chk("ch2_drained_usedw", usedw, '0);
    chk("ch2_no_flags", {overflow, underflow}, 2'b00);

    // ch1: almost_full threshold, full, overflow
    for (int i = 0; i < 29; i++) begin
      wrreq = 1'b1; wr_channel = 2'd1; data = 64'h100 + 64'(i);
      step();
    end
    chk("ch1_usedw29", uw(1), 6'd29);
    chk("ch1_af_at29", almost_full, 4'b0000);
    data = 64'h100 + 64'd29;
    step();
    chk("ch1_usedw30", uw(1), 6'd30);
    chk("ch1_af_at30", almost_full, 4'b0010);
    for (int i = 30; i < 32; i++) begin
      data = 64'h100 + 64'(i);
      step();
    end
    chk("ch1_full", full, 4'b0010);
    chk("ch1_ovf_before", overflow, 1'b0);
    data = 64'hDEAD;
    step();
    wrreq = 1'b0;
    chk("ch1_ovf", overflow, 1'b1);
    chk("ch1_usedw_stays32", uw(1), 6'd32);
    // write to full ch1 with a same-cycle read: read taken, write dropped
    wrreq = 1'b1; wr_channel = 2'd1; data = 64'hBEEF;
    rdreq = 1'b1; rd_channel = 2'd1;
    step();
    wrreq = 1'b0; rdreq = 1'b0;
    chk("ch1_rw_full_usedw", uw(1), 6'd31);
    for (int i = 0; i < 31; i++) begin
      rd_channel = 2'd1; rdreq = 1'b1;
      #1;
      chk("ch1_q", q, 64'h101 + 64'(i));
      step();
    end
    rdreq = 1'b0;
    chk("ch1_drained", empty, 4'hF);
    chk("ch1_unf_clear", underflow, 1'b0);

    // Underflow on empty ch0 with same-cycle write
    rdreq = 1'b1; rd_channel = 2'd0;
    wrreq = 1'b1; wr_channel = 2'd0; data = 64'h55;
    step();
    rdreq = 1'b0; wrreq = 1'b0;
    chk("unf_flag", underflow, 1'b1);
    chk("unf_usedw0", uw(0), 6'd1);
    chk("unf_q", q, 64'h55);
    rdreq = 1'b1;
    step();
    rdreq = 1'b0;
    chk("unf_pop", uw(0), 6'd0);

    // Interleave: ch0 and ch3 preloaded to 16, then 100 cycles write ch3 / read ch0
    for (int i = 0; i < 16; i++) begin
      wrreq = 1'b1; wr_channel = 2'd0; data = 64'h200 + 64'(i);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      wrreq = 1'b1; wr_channel = 2'd3; data = 64'h300 + 64'(i);
      m3.push_back(64'h300 + 64'(i));
      step();
    end
    wrreq = 1'b0;
    c0 = 16; c3 = 16;
    chk("il_pre0", uw(0), 6'd16);
    chk("il_pre3", uw(3), 6'd16);
    for (int k = 0; k < 100; k++) begin
      wrreq = 1'b1; wr_channel = 2'd3; data = 64'h400 + 64'(k);
      rdreq = 1'b1; rd_channel = 2'd0;
      #1;
      if (c0 > 0) chk("il_q0", q, 64'h200 + 64'(16 - c0));
      if (c3 < 32) begin m3.push_back(64'h400 + 64'(k)); c3++; end
      if (c0 > 0) c0--;
      step();
      chk("il_usedw0", uw(0), 6'(c0));
      chk("il_usedw3", uw(3), 6'(c3));
    end
    wrreq = 1'b0; rdreq = 1'b0;
    chk("il_full3", full, 4'b1000);
    chk("il_ovf", overflow, 1'b1);
    for (int i = 0; i < 32; i++) begin
      rd_channel = 2'd3; rdreq = 1'b1;
      #1;
      chk("il_q3", q, m3.pop_front());
      step();
    end
    rdreq = 1'b0;
    chk("il_all_empty", empty, 4'hF);
    chk("il_none_full", full, 4'h0);

    // Reset mid-operation with ch1 half full
    for (int i = 0; i < 16; i++) begin
      wrreq = 1'b1; wr_channel = 2'd1; data = 64'h600 + 64'(i);
      step();
    end
    chk("mid_usedw1", uw(1), 6'd16);
    rst = 1'b1; data = 64'h777;
    #1;
    chk("mid_rst_full", full, 4'hF);
    step();
    rst = 1'b0; wrreq = 1'b0;
    #1;
    chk("post_rst_empty", empty, 4'hF);
    chk("post_rst_full", full, 4'h0);
    chk("post_rst_usedw", usedw, '0);
    chk("post_rst_flags", {overflow, underflow}, 2'b00);
    wrreq = 1'b1; wr_channel = 2'd1; data = 64'h888;
    step();
    wrreq = 1'b0; rd_channel = 2'd1;
    #1;
    chk("post_rst_q", q, 64'h888);
    chk("post_rst_usedw1", uw(1), 6'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
